// File: rtl/mmcm_ps_sched.sv
// MMCM dynamic phase-shift scheduler. It arbitrates hardware step pulses against
// software multi-step commands, issues one psen at a time and tracks net position.
module mmcm_ps_sched #(
  parameter int POS_W     = 16,
  parameter int PEND_W    = 4,
  parameter int POS_LIMIT = 1120,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              ena,
  input  logic              hw_inc,
  input  logic              hw_dec,
  input  logic              sw_start,
  input  logic              sw_dir,
  input  logic [POS_W-1:0]  sw_steps,
  input  logic              err_clr,
  output logic              psen,
  output logic              psincdec,
  input  logic              psdone,
  output logic              busy,
  output logic              sw_busy,
  output logic [PEND_W-1:0] hw_pending,
  output logic [POS_W-1:0]  position,
  output logic              err_timeout,
  output logic              err_limit,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]         TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic signed [PEND_W-1:0] PEND_MAX = {1'b0, {(PEND_W-1){1'b1}}};
  localparam logic signed [PEND_W-1:0] PEND_MIN = {1'b1, {(PEND_W-1){1'b0}}};
  localparam logic signed [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic signed [POS_W-1:0]  POS_ONE  = POS_W'(1);
  localparam logic signed [POS_W:0]    EXT_ONE  = (POS_W+1)'(1);
  localparam logic signed [POS_W:0]    LIM_HI   = (POS_W+1)'(POS_LIMIT);
  localparam logic signed [POS_W:0]    LIM_LO   = -LIM_HI;

  logic [1:0]               r_state;
  logic signed [PEND_W-1:0] r_pend;
  logic [POS_W-1:0]         r_remaining;
  logic                     r_sw_dir;
  logic                     r_sw_busy;
  logic signed [POS_W-1:0]  r_pos;
  logic                     r_last_grant;  // 1 = last grant went to SW
  logic                     r_dir;
  logic [TMO_W-1:0]         r_tmo_cnt;
  logic                     r_err_timeout;
  logic                     r_err_limit;

  logic                     w_hw_req;
  logic                     w_sw_req;
  logic                     w_arb;
  logic                     w_grant_sw;
  logic                     w_grant_dir;
  logic signed [POS_W:0]    w_pos_ext;
  logic signed [POS_W:0]    w_target;
  logic                     w_over_limit;
  logic                     w_hw_step;
  logic signed [PEND_W-1:0] w_pend_base;
  logic signed [PEND_W-1:0] w_pend_next;
  logic                     w_sw_load;

  always_comb begin
    w_hw_req    = (r_pend != '0);
    w_sw_req    = (r_remaining != '0);
    w_arb       = (r_state == S_IDLE) & ena & (w_hw_req | w_sw_req);
    // Round-robin: with both requesting, the side that did not win last time goes.
    w_grant_sw  = w_sw_req & (~w_hw_req | ~r_last_grant);
    w_grant_dir = w_grant_sw ? r_sw_dir : ~r_pend[PEND_W-1];
    w_pos_ext   = {r_pos[POS_W-1], r_pos};
    w_target    = w_grant_dir ? (w_pos_ext + EXT_ONE) : (w_pos_ext - EXT_ONE);
    w_over_limit = (w_target > LIM_HI) | (w_target < LIM_LO);
    w_hw_step   = w_arb & ~w_grant_sw;

    w_pend_base = r_pend;
    if (w_hw_step) begin
      w_pend_base = r_pend[PEND_W-1] ? (r_pend + PEND_ONE) : (r_pend - PEND_ONE);
    end
    w_pend_next = w_pend_base;
    if (hw_inc & ~hw_dec & (w_pend_base != PEND_MAX)) begin
      w_pend_next = w_pend_base + PEND_ONE;
    end else if (hw_dec & ~hw_inc & (w_pend_base != PEND_MIN)) begin
      w_pend_next = w_pend_base - PEND_ONE;
    end

    w_sw_load = sw_start & ~r_sw_busy & (sw_steps != '0) & ena;
  end

  // Phase-shift handshake: psen is a one-cycle request with psincdec valid alongside
  // it and held until the step resolves; the MMCM answers with a one-cycle psdone.
  // Only one request is ever outstanding, and psdone outside WAIT is ignored.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_pend        <= '0;
      r_remaining   <= '0;
      r_sw_dir      <= 1'b0;
      r_sw_busy     <= 1'b0;
      r_pos         <= '0;
      r_last_grant  <= 1'b0;
      r_dir         <= 1'b0;
      r_tmo_cnt     <= '0;
      r_err_timeout <= 1'b0;
      r_err_limit   <= 1'b0;
    end else if (!ena) begin
      // Link down resets the MMCM, so the phase bookkeeping restarts from zero.
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_remaining <= '0;
      r_sw_busy   <= 1'b0;
      r_pos       <= '0;
      r_tmo_cnt   <= '0;
      if (err_clr) begin
        r_err_timeout <= 1'b0;
        r_err_limit   <= 1'b0;
      end
    end else begin
      r_pend <= w_pend_next;
      if (err_clr) begin
        r_err_timeout <= 1'b0;
        r_err_limit   <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_arb) begin
            r_last_grant <= w_grant_sw;
            if (w_over_limit) begin
              r_err_limit <= 1'b1;
              if (w_grant_sw) begin
                r_remaining <= '0;
                r_sw_busy   <= 1'b0;
              end
            end else begin
              r_dir   <= w_grant_dir;
              r_state <= S_ISSUE;
              if (w_grant_sw) begin
                r_remaining <= r_remaining - POS_W'(1);
              end
            end
          end
        end
        S_ISSUE: begin
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (psdone) begin
            r_pos   <= r_dir ? (r_pos + POS_ONE) : (r_pos - POS_ONE);
            r_state <= S_GAP;
            if (r_last_grant && (r_remaining == '0)) begin
              r_sw_busy <= 1'b0;
            end
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_err_timeout <= 1'b1;
            r_pend        <= '0;
            r_remaining   <= '0;
            r_sw_busy     <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (w_sw_load) begin
        r_remaining <= sw_steps;
        r_sw_dir    <= sw_dir;
        r_sw_busy   <= 1'b1;
      end
    end
  end

  assign psen        = (r_state == S_ISSUE);
  assign psincdec    = r_dir;
  assign busy        = (r_state != S_IDLE);
  assign sw_busy     = r_sw_busy;
  assign hw_pending  = r_pend;
  assign position    = r_pos;
  assign err_timeout = r_err_timeout;
  assign err_limit   = r_err_limit;
  assign dbg_state   = r_state;

endmodule
